if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the scratchpad memory (spm) IF port.
- Owns the fetch PC and drives spm read requests on if_spm_*.
- Aligns the registered spm read data with the PC it belongs to and hands an (if_pc, if_insn, if_en) triple to decode.
- Handles decode stall, pipeline flush and taken branches.

Parameters:
- ADDR_W, 12: spm word-address width; the PC is a word address.
- DATA_W, 32: instruction width.
- RESET_PC, 0: first fetch address after reset.
- NOP_INSN, 32'h0000_0013: value driven on if_insn whenever if_en=0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  decode cannot accept; hold the IF/ID output.
- flush  in  1  kill in-flight fetch and redirect to flush_pc.
- flush_pc  in  ADDR_W  redirect target for flush.
- br_taken  in  1  taken branch; redirect to br_addr.
- br_addr  in  ADDR_W  branch target.
- if_spm_addr  out  ADDR_W  spm read address.
- if_spm_as_  out  1  spm address strobe, active-low.
- if_spm_rw  out  1  constant READ (1).
- if_spm_wr_data  out  DATA_W  constant 0.
- if_spm_rd_data  in  DATA_W  spm read data, valid one cycle after the address.
- if_pc  out  ADDR_W  address of if_insn.
- if_insn  out  DATA_W  fetched instruction.
- if_en  out  1  if_insn/if_pc valid.

Behaviour:
- Registers:
  - pc: next fetch address.
  - if_pc: address issued last cycle.
  - if_en.
- spm latency is fixed at 1 cycle. if_insn = if_en ? if_spm_rd_data : NOP_INSN (combinational from the spm output).
- Reset (rst=1, asynchronous):
  - pc=RESET_PC, if_pc=0, if_en=0.
  - Outputs: if_spm_as_=1, if_insn=NOP_INSN, if_spm_rw=1, if_spm_wr_data=0.
- Addressing:
  - if_spm_addr = stall ? if_pc : pc. During a stall the spm re-reads if_pc, so rd_data stays valid.
  - if_spm_as_ = 0 whenever rst=0.
- Next-state priority per rising edge (rst=0):
  - flush: pc<=flush_pc; if_en<=0; if_pc unchanged.
  - else br_taken: pc<=br_addr; if_en<=0.
  - else stall: pc, if_pc and if_en all held.
  - else advance: if_pc<=pc; pc<=pc+1; if_en<=1.
- Timing:
  - Redirect: target address goes to the spm the cycle after flush/br_taken; the first valid target insn appears on if_en 2 cycles after the redirect edge.
  - After reset release: RESET_PC is issued in cycle 0; if_en=1 with if_pc=RESET_PC in cycle 1.
- Wrap-around: pc+1 is modulo 2^ADDR_W (0xFFF -> 0x000); no error flag.
- Simultaneous events:
  - flush+br_taken: flush wins.
  - flush or br_taken together with stall: the redirect wins and the stall is ignored that edge.
- Stall with if_en=0: state held; outputs remain NOP_INSN / if_en=0.
- rst asserted mid-stall or mid-redirect: immediate return to the reset values; nothing is retained.

Optional Feature:
- Macro: IF_HOLD_BUF_EN.
- Defined:
  - A DATA_W hold buffer plus hold_vld flag.
  - On the first stall cycle with if_en=1, capture if_spm_rd_data at the edge and set hold_vld.
  - if_spm_as_=1 while stall=1 (spm idle, saves power).
  - if_insn = hold_vld ? hold_buf : rd_data (still NOP when if_en=0).
  - In the stall-release cycle: drive the hold buffer, issue address pc with as_=0, clear hold_vld at the edge.
  - flush, br_taken or rst clear hold_vld.
- Undefined: no buffer; stall re-reads if_pc with as_=0 as described above.

Decomposition:
- Shared package holds:
  - READ=1 / WRITE=0 constants.
  - NOP_INSN.
  - Default ADDR_W/DATA_W for the spm interface, shared with spm and the mem stage.
- One natural sub-module: if_pc_next, a combinational next-PC priority mux (flush/branch/stall/increment with wrap).
- The hold buffer stays inline.

Test Plan (spm preloaded word i = i):
- Reset release at RESET_PC=0 -> cycle 0 if_en=0 and insn=NOP; cycle 1 if_pc=0, insn=0; cycle 2 if_pc=1, insn=1.
- stall for 3 cycles while if_pc=5 -> if_pc=5, insn=5, if_en=1 held all 3 cycles; the cycle after release shows if_pc=6, insn=6. Repeat with IF_HOLD_BUF_EN: same outputs, and if_spm_as_=1 during the stall.
- br_taken with br_addr=20 at if_pc=7 -> next cycle if_en=0; the following cycle if_pc=20, insn=20.
- flush (flush_pc=3) and br_taken (br_addr=30) together with stall -> stall ignored; two cycles later if_pc=3, insn=3.
- Redirect to 0xFFE -> if_pc sequence 0xFFE, 0xFFF, 0x000, 0x001 with no bubble at the wrap.
- rst asserted asynchronously mid-stall -> if_en=0, if_insn=NOP and if_spm_as_=1 immediately; after release, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage and its neighbours on the
// scratchpad memory (spm) interface.
//   - spm_rw_e     : spm access direction (READ=1, WRITE=0)
//   - SPM_ADDR_W   : default spm word-address width (shared with spm / mem stage)
//   - SPM_DATA_W   : default spm data width
//   - NOP_INSN_DEF : instruction presented to decode when no valid fetch exists
//   - pc_sel_e     : which rule selected the next fetch PC
// -----------------------------------------------------------------------------
package if_stage_pkg;

   localparam int SPM_ADDR_W = 12;
   localparam int SPM_DATA_W = 32;

   localparam logic [SPM_DATA_W-1:0] NOP_INSN_DEF = 32'h0000_0013;

   typedef enum logic {
      WRITE = 1'b0,
      READ  = 1'b1
   } spm_rw_e;

   typedef enum logic [1:0] {
      SEL_FLUSH   = 2'd0,
      SEL_BRANCH  = 2'd1,
      SEL_HOLD    = 2'd2,
      SEL_ADVANCE = 2'd3
   } pc_sel_e;

endpackage

// File: rtl/if_pc_next.sv
// -----------------------------------------------------------------------------
// if_pc_next
// Combinational next-PC priority mux for the fetch stage.
// Priority: flush > taken branch > stall (hold) > sequential advance.
// The increment wraps modulo 2^ADDR_W without any flag.
// Ports:
//   pc        in   current fetch PC
//   stall     in   decode stall
//   flush     in   pipeline flush
//   flush_pc  in   flush redirect target
//   br_taken  in   taken branch
//   br_addr   in   branch target
//   pc_next   out  PC to load at the next rising edge
//   sel       out  rule that produced pc_next (drives the IF/ID register update)
// -----------------------------------------------------------------------------
module if_pc_next
   import if_stage_pkg::*;
#(
   parameter int ADDR_W = SPM_ADDR_W
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   output logic [ADDR_W-1:0] pc_next,
   output pc_sel_e           sel
);

   always_comb begin
      pc_next = pc + ADDR_W'(1);
      sel     = SEL_ADVANCE;
      // A redirect overrides a simultaneous stall.
      if (flush) begin
         pc_next = flush_pc;
         sel     = SEL_FLUSH;
      end else if (br_taken) begin
         pc_next = br_addr;
         sel     = SEL_BRANCH;
      end else if (stall) begin
         pc_next = pc;
         sel     = SEL_HOLD;
      end
   end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage in front of the spm IF port. Owns the fetch PC,
// issues spm reads, and aligns the registered spm read data (1-cycle latency)
// with the PC it belongs to, presenting (if_pc, if_insn, if_en) to decode.
//
// Optional feature (macro IF_HOLD_BUF_EN): a hold buffer captures the
// instruction on the first stall cycle so the spm can be left idle
// (if_spm_as_=1) for the rest of the stall.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   stall           decode cannot accept; hold IF/ID output
//   flush, flush_pc kill in-flight fetch, redirect to flush_pc
//   br_taken,br_addr taken branch, redirect to br_addr
//   if_spm_addr     spm read address
//   if_spm_as_      spm address strobe, active-low
//   if_spm_rw       constant READ
//   if_spm_wr_data  constant 0
//   if_spm_rd_data  spm read data, valid one cycle after the address
//   if_pc           address of if_insn
//   if_insn         fetched instruction (NOP_INSN when if_en=0)
//   if_en           if_pc/if_insn valid
// -----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = SPM_ADDR_W,
   parameter int                DATA_W   = SPM_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [DATA_W-1:0] NOP_INSN = NOP_INSN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   output logic [ADDR_W-1:0] if_spm_addr,
   output logic              if_spm_as_,
   output logic              if_spm_rw,
   output logic [DATA_W-1:0] if_spm_wr_data,
   input  logic [DATA_W-1:0] if_spm_rd_data,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_insn,
   output logic              if_en
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   pc_sel_e           sel;

   if_pc_next #(
      .ADDR_W (ADDR_W)
   ) u_pc_next (
      .pc       (pc),
      .stall    (stall),
      .flush    (flush),
      .flush_pc (flush_pc),
      .br_taken (br_taken),
      .br_addr  (br_addr),
      .pc_next  (pc_next),
      .sel      (sel)
   );

   // ---- fetch PC / IF-ID register boundary ----
   // if_pc trails pc by one cycle, matching the spm read latency, so the
   // registered rd_data always belongs to if_pc. A redirect leaves if_pc
   // alone; if_en=0 already marks it invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc    <= RESET_PC;
         if_pc <= '0;
         if_en <= 1'b0;
      end else begin
         pc <= pc_next;
         case (sel)
            SEL_FLUSH,
            SEL_BRANCH: if_en <= 1'b0;
            SEL_ADVANCE: begin
               if_pc <= pc;
               if_en <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // While stalled, re-address if_pc so the spm keeps returning the
   // instruction decode is holding.
   assign if_spm_addr    = stall ? if_pc : pc;
   assign if_spm_rw      = READ;
   assign if_spm_wr_data = '0;

`ifdef IF_HOLD_BUF_EN
   logic [DATA_W-1:0] hold_buf;
   logic              hold_vld;
   logic              hold_capture;

   // First stall cycle with a valid instruction: rd_data still holds the
   // word read for if_pc, so grab it before the spm goes idle.
   assign hold_capture = stall && if_en && !hold_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_vld <= 1'b0;
      end else if (sel == SEL_FLUSH || sel == SEL_BRANCH) begin
         hold_vld <= 1'b0;
      end else if (hold_capture) begin
         hold_vld <= 1'b1;
      end else if (!stall) begin
         hold_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (hold_capture) begin
         hold_buf <= if_spm_rd_data;
      end
   end

   assign if_spm_as_ = rst | stall;
   assign if_insn    = !if_en   ? NOP_INSN :
                       hold_vld ? hold_buf : if_spm_rd_data;
`else
   assign if_spm_as_ = rst;
   assign if_insn    = if_en ? if_spm_rd_data : NOP_INSN;
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage with an spm model (word i holds value i,
// junk on the read port whenever the strobe was inactive) and a reference
// model of the fetch rules. Directed scenarios followed by random stimulus.
// Honours IF_HOLD_BUF_EN for the expected address-strobe behaviour.
// -----------------------------------------------------------------------------
module tb_if_stage;
   import if_stage_pkg::*;

   localparam int          AW  = 12;
   localparam int          DW  = 32;
   localparam logic [DW-1:0] NOP = 32'h0000_0013;
`ifdef IF_HOLD_BUF_EN
   localparam bit HOLD_MODE = 1'b1;
`else
   localparam bit HOLD_MODE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          stall, flush, br_taken;
   logic [AW-1:0] flush_pc, br_addr;
   logic [AW-1:0] if_spm_addr;
   logic          if_spm_as_;
   logic          if_spm_rw;
   logic [DW-1:0] if_spm_wr_data;
   logic [DW-1:0] if_spm_rd_data;
   logic [AW-1:0] if_pc;
   logic [DW-1:0] if_insn;
   logic          if_en;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [AW-1:0] m_pc, m_ifpc;
   logic          m_en;

   // outputs sampled by the last step
   logic          s_en, s_as;
   logic [AW-1:0] s_pc, s_addr;
   logic [DW-1:0] s_insn;

   if_stage #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RESET_PC ('0),
      .NOP_INSN (NOP)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .flush_pc       (flush_pc),
      .br_taken       (br_taken),
      .br_addr        (br_addr),
      .if_spm_addr    (if_spm_addr),
      .if_spm_as_     (if_spm_as_),
      .if_spm_rw      (if_spm_rw),
      .if_spm_wr_data (if_spm_wr_data),
      .if_spm_rd_data (if_spm_rd_data),
      .if_pc          (if_pc),
      .if_insn        (if_insn),
      .if_en          (if_en)
   );

   always #5 clk = ~clk;

   // spm: word i = i, one-cycle read latency, garbage when not strobed
   always @(posedge clk) begin
      if (!if_spm_as_) if_spm_rd_data <= DW'(if_spm_addr);
      else             if_spm_rd_data <= $urandom();
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = '0;
      m_ifpc = '0;
      m_en   = 1'b0;
   endtask

   // One rising edge of the fetch rules.
   task automatic model_edge();
      if (flush) begin
         m_pc = flush_pc; m_en = 1'b0;
      end else if (br_taken) begin
         m_pc = br_addr;  m_en = 1'b0;
      end else if (!stall) begin
         m_ifpc = m_pc;   m_pc = m_pc + 1'b1;   m_en = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic          e_as;
      logic [DW-1:0] e_insn;
      e_as   = rst | (HOLD_MODE & stall);
      e_insn = m_en ? DW'(m_ifpc) : NOP;
      chk({tag, ".en"},   64'(if_en),   64'(m_en));
      chk({tag, ".insn"}, 64'(if_insn), 64'(e_insn));
      chk({tag, ".as_"},  64'(if_spm_as_), 64'(e_as));
      chk({tag, ".rw"},   64'(if_spm_rw), 64'(1'b1));
      chk({tag, ".wdat"}, 64'(if_spm_wr_data), 64'(0));
      if (!rst) begin
         chk({tag, ".addr"}, 64'(if_spm_addr), 64'(stall ? m_ifpc : m_pc));
         if (m_en) chk({tag, ".pc"}, 64'(if_pc), 64'(m_ifpc));
      end
   endtask

   // Called #1 after a rising edge: drive inputs, check mid-cycle, take edge.
   task automatic step(input logic s, input logic f, input logic [AW-1:0] fp,
                       input logic b, input logic [AW-1:0] ba, input string tag);
      stall = s; flush = f; flush_pc = fp; br_taken = b; br_addr = ba;
      @(negedge clk);
      s_en = if_en; s_pc = if_pc; s_insn = if_insn; s_as = if_spm_as_; s_addr = if_spm_addr;
      check_outputs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic adv(input string tag);
      step(1'b0, 1'b0, '0, 1'b0, '0, tag);
   endtask

   // Asynchronous reset pulse starting mid-cycle, released #1 after an edge.
   task automatic rst_pulse(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk({tag, ".en"},   64'(if_en), 64'(0));
      chk({tag, ".insn"}, 64'(if_insn), 64'(NOP));
      chk({tag, ".as_"},  64'(if_spm_as_), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
      flush_pc = '0; br_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs("in_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // reset release
      adv("c0");
      chk("c0.en", 64'(s_en), 64'(0));
      chk("c0.insn", 64'(s_insn), 64'(NOP));
      chk("c0.addr", 64'(s_addr), 64'(0));
      adv("c1");
      chk("c1.pc", 64'(s_pc), 64'(0));
      chk("c1.insn", 64'(s_insn), 64'(0));
      adv("c2");
      chk("c2.pc", 64'(s_pc), 64'(1));
      chk("c2.insn", 64'(s_insn), 64'(1));
      adv("c3"); adv("c4"); adv("c5");

      // 3-cycle stall at if_pc=5
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, '0, 1'b0, '0, "stall");
         chk("stall.pc", 64'(s_pc), 64'(5));
         chk("stall.insn", 64'(s_insn), 64'(5));
         chk("stall.en", 64'(s_en), 64'(1));
         chk("stall.as_", 64'(s_as), 64'(HOLD_MODE));
      end
      adv("release");
      chk("release.insn", 64'(s_insn), 64'(5));
      chk("release.as_", 64'(s_as), 64'(0));
      adv("after_rel");
      chk("after_rel.pc", 64'(s_pc), 64'(6));
      chk("after_rel.insn", 64'(s_insn), 64'(6));

      // taken branch at if_pc=7
      step(1'b0, 1'b0, '0, 1'b1, 12'd20, "br");
      chk("br.pc", 64'(s_pc), 64'(7));
      adv("br+1");
      chk("br+1.en", 64'(s_en), 64'(0));
      chk("br+1.addr", 64'(s_addr), 64'(20));
      adv("br+2");
      chk("br+2.pc", 64'(s_pc), 64'(20));
      chk("br+2.insn", 64'(s_insn), 64'(20));

      // flush + branch + stall together
      step(1'b1, 1'b1, 12'd3, 1'b1, 12'd30, "fbs");
      adv("fbs+1");
      chk("fbs+1.en", 64'(s_en), 64'(0));
      adv("fbs+2");
      chk("fbs+2.pc", 64'(s_pc), 64'(3));
      chk("fbs+2.insn", 64'(s_insn), 64'(3));

      // wrap-around
      step(1'b0, 1'b0, '0, 1'b1, 12'hFFE, "wrap_br");
      adv("wrap0");
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] e;
         e = 12'hFFE + AW'(i);
         adv("wrap");
         chk("wrap.pc", 64'(s_pc), 64'(e));
         chk("wrap.insn", 64'(s_insn), 64'(e));
         chk("wrap.en", 64'(s_en), 64'(1));
      end

      // asynchronous reset mid-stall
      step(1'b1, 1'b0, '0, 1'b0, '0, "pre_rst");
      chk("pre_rst.en", 64'(s_en), 64'(1));
      stall = 1'b1;
      rst_pulse("rst_stall");
      adv("r0");
      chk("r0.en", 64'(s_en), 64'(0));
      chk("r0.addr", 64'(s_addr), 64'(0));
      adv("r1");
      chk("r1.pc", 64'(s_pc), 64'(0));
      chk("r1.insn", 64'(s_insn), 64'(0));

      // random traffic
      for (int n = 0; n < 500; n++) begin
         logic          rs, rf, rb;
         logic [AW-1:0] fp, ba;
         if ($urandom_range(99) < 2) begin
            stall = $urandom_range(1);
            rst_pulse("rnd_rst");
         end
         rs = ($urandom_range(99) < 40);
         rf = ($urandom_range(99) < 6);
         rb = ($urandom_range(99) < 8);
         fp = ($urandom_range(3) == 0) ? AW'(12'hFFC + $urandom_range(3)) : AW'($urandom());
         ba = AW'($urandom());
         step(rs, rf, fp, rb, ba, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
